square_root: RTL and testbench

- Sequential fixed-point square-root unit.
- Takes an 8-bit unsigned integer and returns floor(sqrt(in) * 256) as a 16-bit unsigned Q8.8 value.
- Uses a start/done handshake and computes one result bit per clock (digit-by-digit restoring algorithm).
- Serves as an arithmetic helper block for datapath logic that needs non-integer roots of small integers.

---
 rtl/square_root_if.sv | 31 +++
 rtl/square_root.sv | 89 ++++++++
 tb/tb_square_root.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/square_root_if.sv
// rtl/square_root_if.sv - start/done handshake bundle for the square-root unit
//
// Signals:
//   start  requester -> unit   request a new computation (sampled while idle)
//   in     requester -> unit   8-bit unsigned radicand
//   busy   unit -> requester   computation in progress
//   done   unit -> requester   one-cycle pulse, out holds a new result
//   out    unit -> requester   Q8.8 unsigned result
interface square_root_if;
  logic        start;
  logic [7:0]  in;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (
    output start,
    output in,
    input  busy,
    input  done,
    input  out
  );

  modport slave (
    input  start,
    input  in,
    output busy,
    output done,
    output out
  );
endinterface

// File: rtl/square_root.sv
// rtl/square_root.sv - sequential Q8.8 square root of an 8-bit integer
//
// Computes out = floor(sqrt(in * 65536)) with a digit-by-digit restoring
// algorithm, one result bit per clock, 12 clocks from accept to done.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   square_root_if slave: start/in in, busy/done/out out
module square_root (
  input  logic         clk,
  input  logic         rst,
  square_root_if.slave bus
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      state_q;
  logic [23:0] rad_q;   // radicand {in, 16'h0}, consumed two bits per step
  logic [15:0] rem_q;   // partial remainder; stays below 2^14
  logic [11:0] root_q;
  logic [3:0]  cnt_q;   // steps remaining minus one
  logic [15:0] out_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] rem_shift;
  logic [15:0] trial;
  logic [15:0] diff;
  logic        fits;
  logic [15:0] rem_d;
  logic [11:0] root_d;

  // One restoring step: bring down the next radicand bit pair and try to
  // subtract 4*root+1; success sets the new root bit.
  always_comb begin
    rem_shift = (rem_q << 2) | {14'd0, rad_q[23:22]};
    trial     = {2'b00, root_q, 2'b01};
    diff      = rem_shift - trial;
    fits      = (rem_shift >= trial);
    rem_d     = fits ? diff : rem_shift;
    root_d    = {root_q[10:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= 24'h0;
      rem_q   <= 16'h0;
      root_q  <= 12'h0;
      cnt_q   <= 4'h0;
      out_q   <= 16'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rad_q   <= {bus.in, 16'h0};
            rem_q   <= 16'h0;
            root_q  <= 12'h0;
            cnt_q   <= 4'd11;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rad_q  <= rad_q << 2;
          rem_q  <= rem_d;
          root_q <= root_d;
          cnt_q  <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            out_q   <= {4'h0, root_d};
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_square_root.sv
// tb/tb_square_root.sv - self-checking bench for square_root
module tb_square_root;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  square_root_if bus ();

  square_root dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: largest r with r*r <= in*65536, found by plain search.
  function automatic int ref_sqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v * 65536) r++;
    return r;
  endfunction

  // Issue one request from idle; report result and accept-to-done latency.
  task automatic do_op(input logic [7:0] v, output logic [15:0] res, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in    = 8'($urandom);
    lat = 0;
    res = 16'h0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    res = bus.out;
  endtask

  task automatic test_reset();
    logic seen_done;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.out !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h busy=%b done=%b, need out=0000 busy=0 done=0", bus.out, bus.busy, bus.done);
    end
    // Abort a computation part-way through.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = 8'd169;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.out !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: out=%h busy=%b done=%b, need out=0000 busy=0 done=0", bus.out, bus.busy, bus.done);
    end
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy || bus.out !== 16'h0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_no_done: activity after aborted op (seen=1), need none (seen=0)");
    end
  endtask

  task automatic test_exact_squares();
    logic [7:0]  vin [5] = '{8'd0, 8'd169, 8'd64, 8'd25, 8'd1};
    logic [15:0] vexp[5] = '{16'h0000, 16'h0D00, 16'h0800, 16'h0500, 16'h0100};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(vin[i], res, lat);
      checks++;
      if (res !== vexp[i] || lat !== 12) begin
        errors++;
        $display("FAIL exact_square in=%0d: out=%h lat=%0d, need out=%h lat=12", vin[i], res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_non_squares();
    logic [7:0]  vin [3] = '{8'd82, 8'd2, 8'd255};
    logic [15:0] vexp[3] = '{16'h090E, 16'h016A, 16'h0FF7};
    logic [15:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(vin[i], res, lat);
      checks++;
      if (res !== vexp[i] || lat !== 12) begin
        errors++;
        $display("FAIL non_square in=%0d: out=%h lat=%0d, need out=%h lat=12", vin[i], res, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    a = 8'($urandom);
    b = a ^ 8'h5A;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 4;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    checks++;
    if (bus.out !== 16'(ref_sqrt(int'(a))) || lat !== 12) begin
      errors++;
      $display("FAIL busy_ignore a=%0d b=%0d: out=%h lat=%0d, need out=%h lat=12", a, b, bus.out, lat, 16'(ref_sqrt(int'(a))));
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_idle: busy=%b done=%b, need busy=0 done=0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    int lat;
    a = 8'($urandom);
    b = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = a;
    @(posedge clk);
    #1;
    bus.in = b;  // start stays high through done
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    checks++;
    if (bus.out !== 16'(ref_sqrt(int'(a))) || lat !== 12 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first a=%0d: out=%h lat=%0d busy=%b, need out=%h lat=12 busy=0", a, bus.out, lat, bus.busy, 16'(ref_sqrt(int'(a))));
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.out !== 16'(ref_sqrt(int'(a)))) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b out=%h, need done=0 busy=1 out=%h", bus.done, bus.busy, bus.out, 16'(ref_sqrt(int'(a))));
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    checks++;
    if (bus.out !== 16'(ref_sqrt(int'(b))) || lat !== 12) begin
      errors++;
      $display("FAIL b2b_second b=%0d: out=%h lat=%0d, need out=%h lat=12", b, bus.out, lat, 16'(ref_sqrt(int'(b))));
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse_width: done=%b one cycle after pulse, need 0", bus.done);
    end
  endtask

  task automatic test_input_stability();
    logic [15:0] prev;
    logic [7:0]  b;
    logic        held;
    int lat;
    do_op(8'($urandom), prev, lat);
    b = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in = ~b;
    held = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
      if (bus.out !== prev || bus.busy !== 1'b1) held = 1'b0;
      bus.in = 8'($urandom);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL out_hold_busy: out/busy changed during computation (held=0), need held=1");
    end
    checks++;
    if (bus.out !== 16'(ref_sqrt(int'(b))) || lat !== 12) begin
      errors++;
      $display("FAIL input_capture b=%0d: out=%h lat=%0d, need out=%h lat=12", b, bus.out, lat, 16'(ref_sqrt(int'(b))));
    end
  endtask

  task automatic test_sweep();
    logic [15:0] res;
    int lat;
    for (int v = 0; v < 256; v++) begin
      do_op(8'(v), res, lat);
      checks++;
      if (res !== 16'(ref_sqrt(v)) || res[15:12] !== 4'h0 || lat !== 12) begin
        errors++;
        $display("FAIL sweep in=%0d: out=%h lat=%0d, need out=%h lat=12", v, res, lat, 16'(ref_sqrt(v)));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.in = 8'h0;
    test_reset();
    test_exact_squares();
    test_non_squares();
    test_busy_ignore();
    test_back_to_back();
    test_input_stability();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
